rgb565_grayscale_pipe: RTL and testbench



---
 rtl/rgb565_grayscale_pipe_pkg.sv | 23 ++
 rtl/rgb565_grayscale_pipe_if.sv | 12 +
 rtl/rgb565_grayscale_pipe_luma_lane.sv | 79 +++++++
 rtl/rgb565_grayscale_pipe.sv | 115 +++++++++++
 tb/tb_rgb565_grayscale_pipe.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/rgb565_grayscale_pipe_pkg.sv
// Shared constants and helpers for the RGB565 grayscale custom instruction.
// Config opcodes, default luma weights and the saturating luma extraction.
package grayscale_pkg;

    typedef enum logic [1:0] {
        GS_OP_READ    = 2'd0,
        GS_OP_WRITE   = 2'd1,
        GS_OP_DEFAULT = 2'd2,
        GS_OP_STATS   = 2'd3
    } gs_op_e;

    localparam logic [7:0]  GS_DEF_WR  = 8'd54;
    localparam logic [7:0]  GS_DEF_WG  = 8'd183;
    localparam logic [7:0]  GS_DEF_WB  = 8'd19;
    localparam int          LUMA_SHIFT = 6;
    localparam logic [15:0] SAT_LIMIT  = 16'd16384;

    // Weighted sums at or above 2^14 clamp to white instead of wrapping.
    function automatic logic [7:0] gs_sat(input logic [15:0] sum);
        return (sum >= SAT_LIMIT) ? 8'hFF : sum[LUMA_SHIFT +: 8];
    endfunction

endpackage

// File: rtl/rgb565_grayscale_pipe_if.sv
// Custom-instruction bus bundle for the grayscale block.
interface rgb565_grayscale_pipe_if;
    logic        start;
    logic [31:0] valueA;
    logic [31:0] valueB;
    logic [7:0]  isId;
    logic        done;
    logic [31:0] result;

    modport master (output start, valueA, valueB, isId, input done, result);
    modport slave  (input start, valueA, valueB, isId, output done, result);
endinterface

// File: rtl/rgb565_grayscale_pipe_luma_lane.sv
// One pixel lane: byte-swapped RGB565 unpack, weighted sum, saturate.
// Register placement follows PIPE_STAGES (1..3); stage_en[k] loads stage k+1.
module rgb565_luma_lane
    import grayscale_pkg::*;
#(
    parameter int PIPE_STAGES = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [PIPE_STAGES-1:0] stage_en,
    input  logic [15:0]            pix,
    input  logic [7:0]             wr,
    input  logic [7:0]             wg,
    input  logic [7:0]             wb,
    output logic [7:0]             luma
);

    logic [5:0]  r6, g6, b6;
    logic [15:0] pr, pg, pb;

    // Halfword arrives byte-swapped, so green straddles both bytes.
    assign r6 = {pix[7:3], 1'b0};
    assign g6 = {pix[2:0], pix[15:13]};
    assign b6 = {pix[12:8], 1'b0};

    assign pr = {10'd0, r6} * {8'd0, wr};
    assign pg = {10'd0, g6} * {8'd0, wg};
    assign pb = {10'd0, b6} * {8'd0, wb};

    if (PIPE_STAGES == 1) begin : g_s1
        logic [7:0] luma_q;
        always_ff @(posedge clock or posedge reset) begin
            if (reset)            luma_q <= '0;
            else if (stage_en[0]) luma_q <= gs_sat(pr + pg + pb);
        end
        assign luma = luma_q;
    end else if (PIPE_STAGES == 2) begin : g_s2
        logic [15:0] pr_q, pg_q, pb_q;
        logic [7:0]  luma_q;
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                pr_q   <= '0;
                pg_q   <= '0;
                pb_q   <= '0;
                luma_q <= '0;
            end else begin
                if (stage_en[0]) begin
                    pr_q <= pr;
                    pg_q <= pg;
                    pb_q <= pb;
                end
                if (stage_en[1]) luma_q <= gs_sat(pr_q + pg_q + pb_q);
            end
        end
        assign luma = luma_q;
    end else begin : g_s3
        logic [15:0] pr_q, pg_q, pb_q, sum_q;
        logic [7:0]  luma_q;
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                pr_q   <= '0;
                pg_q   <= '0;
                pb_q   <= '0;
                sum_q  <= '0;
                luma_q <= '0;
            end else begin
                if (stage_en[0]) begin
                    pr_q <= pr;
                    pg_q <= pg;
                    pb_q <= pb;
                end
                if (stage_en[1]) sum_q  <= pr_q + pg_q + pb_q;
                if (stage_en[2]) luma_q <= gs_sat(sum_q);
            end
        end
        assign luma = luma_q;
    end

endmodule

// File: rtl/rgb565_grayscale_pipe.sv
// RGB565 -> 4x8-bit luma custom instruction with programmable weights.
// Optional GRAYSCALE_STATS_EN adds a converted-pixel counter read by config op 3.
module rgb565_grayscale_pipe
    import grayscale_pkg::*;
#(
    parameter logic [7:0] customInstructionId = 8'd0,
    parameter int         PIPE_STAGES         = 2,
    parameter logic [7:0] DEF_WR              = GS_DEF_WR,
    parameter logic [7:0] DEF_WG              = GS_DEF_WG,
    parameter logic [7:0] DEF_WB              = GS_DEF_WB
) (
    input  logic                  clock,
    input  logic                  reset,
    rgb565_grayscale_pipe_if.slave ci
);

    if (PIPE_STAGES < 1 || PIPE_STAGES > 3) begin : g_bad_stages
        $error("rgb565_grayscale_pipe: PIPE_STAGES must be 1..3");
    end

    localparam logic [7:0] CFG_ID = customInstructionId + 8'd1;

    logic [PIPE_STAGES:1] vld_q;
    logic [PIPE_STAGES:0] vld_pipe;
    logic                 busy, launch, cfg_go, cvt_done, cfg_vld;
    logic [7:0]           wr_q, wg_q, wb_q;
    logic [31:0]          cfg_res, stats_val, old_w;
    logic [63:0]          pix_all;
    logic [3:0][7:0]      luma;
    gs_op_e               op;

    assign busy     = |vld_q;
    assign launch   = ci.start && (ci.isId == customInstructionId) && !busy;
    assign cfg_go   = ci.start && (ci.isId == CFG_ID) && !busy;
    assign vld_pipe = {vld_q, launch};
    assign cvt_done = vld_q[PIPE_STAGES];
    assign op       = gs_op_e'(ci.valueA[1:0]);
    assign old_w    = {8'h00, wb_q, wg_q, wr_q};
    assign pix_all  = {ci.valueB, ci.valueA};

    always_ff @(posedge clock or posedge reset) begin
        if (reset) vld_q <= '0;
        else       vld_q <= vld_pipe[PIPE_STAGES-1:0];
    end

    // Lanes read the live weight registers at launch; config is locked out
    // while busy, so an in-flight op always sees its launch weights.
    for (genvar i = 0; i < 4; i++) begin : g_lane
        rgb565_luma_lane #(.PIPE_STAGES(PIPE_STAGES)) u_lane (
            .clock   (clock),
            .reset   (reset),
            .stage_en(vld_pipe[PIPE_STAGES-1:0]),
            .pix     (pix_all[16*i +: 16]),
            .wr      (wr_q),
            .wg      (wg_q),
            .wb      (wb_q),
            .luma    (luma[i])
        );
    end

`ifdef GRAYSCALE_STATS_EN
    logic [31:0] pix_cnt;
    logic        stats_clr;

    assign stats_clr = cfg_go && (op == GS_OP_STATS);

    always_ff @(posedge clock or posedge reset) begin
        if (reset)         pix_cnt <= '0;
        else if (stats_clr) pix_cnt <= cvt_done ? 32'd4 : 32'd0;
        else if (cvt_done)  pix_cnt <= pix_cnt + 32'd4;
    end

    assign stats_val = pix_cnt;
`else
    assign stats_val = '0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_q    <= DEF_WR;
            wg_q    <= DEF_WG;
            wb_q    <= DEF_WB;
            cfg_vld <= 1'b0;
            cfg_res <= '0;
        end else begin
            cfg_vld <= cfg_go;
            if (cfg_go) begin
                case (op)
                    GS_OP_WRITE: begin
                        cfg_res <= old_w;
                        wr_q    <= ci.valueB[7:0];
                        wg_q    <= ci.valueB[15:8];
                        wb_q    <= ci.valueB[23:16];
                    end
                    GS_OP_DEFAULT: begin
                        cfg_res <= old_w;
                        wr_q    <= DEF_WR;
                        wg_q    <= DEF_WG;
                        wb_q    <= DEF_WB;
                    end
                    GS_OP_STATS: cfg_res <= stats_val;
                    default:     cfg_res <= old_w;
                endcase
            end
        end
    end

    always_comb begin
        ci.done   = cvt_done | cfg_vld;
        ci.result = '0;
        if (cvt_done)     ci.result = luma;
        else if (cfg_vld) ci.result = cfg_res;
    end

endmodule

// File: tb/tb_rgb565_grayscale_pipe.sv
// Directed bench for rgb565_grayscale_pipe at PIPE_STAGES=2.
module tb_rgb565_grayscale_pipe;
    import grayscale_pkg::*;

    localparam logic [7:0] CID = 8'd0;
    localparam logic [7:0] CFG = CID + 8'd1;
    localparam logic [7:0] FOREIGN = CID + 8'd5;
`ifdef GRAYSCALE_STATS_EN
    localparam logic [31:0] STATS_EXP = 32'd12;
`else
    localparam logic [31:0] STATS_EXP = 32'd0;
`endif

    logic clock = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    always #5 clock = ~clock;

    rgb565_grayscale_pipe_if bif();

    rgb565_grayscale_pipe #(
        .customInstructionId(CID),
        .PIPE_STAGES        (2)
    ) dut (
        .clock(clock),
        .reset(reset),
        .ci   (bif)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_cvt(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input string tag);
        bif.start  = 1'b1;
        bif.isId   = CID;
        bif.valueA = a;
        bif.valueB = b;
        chk({tag, ".c0_done"}, {31'd0, bif.done}, 32'd0);
        tick();
        bif.start  = 1'b0;
        bif.valueA = '0;
        bif.valueB = '0;
        chk({tag, ".c1_done"}, {31'd0, bif.done}, 32'd0);
        chk({tag, ".c1_res"}, bif.result, 32'd0);
        tick();
        chk({tag, ".c2_done"}, {31'd0, bif.done}, 32'd1);
        chk({tag, ".c2_res"}, bif.result, exp);
        tick();
        chk({tag, ".c3_done"}, {31'd0, bif.done}, 32'd0);
        chk({tag, ".c3_res"}, bif.result, 32'd0);
    endtask

    task automatic do_cfg(input logic [1:0] op, input logic [31:0] data,
                          input logic [31:0] exp, input string tag);
        bif.start  = 1'b1;
        bif.isId   = CFG;
        bif.valueA = {30'd0, op};
        bif.valueB = data;
        tick();
        bif.start  = 1'b0;
        bif.valueA = '0;
        bif.valueB = '0;
        chk({tag, ".done"}, {31'd0, bif.done}, 32'd1);
        chk({tag, ".res"}, bif.result, exp);
        tick();
        chk({tag, ".after"}, {31'd0, bif.done}, 32'd0);
    endtask

    initial begin
        bif.start  = 1'b0;
        bif.isId   = '0;
        bif.valueA = '0;
        bif.valueB = '0;
        reset      = 1'b1;
        tick();
        tick();
        chk("rst.done", {31'd0, bif.done}, 32'd0);
        chk("rst.res", bif.result, 32'd0);
        reset = 1'b0;
        tick();
        chk("idle.done", {31'd0, bif.done}, 32'd0);

        do_cfg(2'd0, 32'd0, 32'h0013B736, "rd_defaults");
        do_cvt(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFAFAFAFA, "cvt_white");
        do_cvt({16'hE007, 16'h00F8}, 32'd0, 32'h0000B434, "cvt_green_red");
        do_cvt({16'h0000, 16'h1F00}, {16'hFFFF, 16'h0000}, 32'hFA000012, "cvt_blue_mix");

        // 128*128 lands exactly on the clamp point; 127*128 just below it
        do_cfg(2'd1, 32'h00808080, 32'h0013B736, "wr_128");
        do_cvt({16'h7FF8, 16'h9FF8}, 32'd0, 32'h0000FEFF, "cvt_sat_edge");

        do_cfg(2'd1, 32'h00FFFFFF, 32'h00808080, "wr_255");
        do_cvt(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "cvt_sat");
        do_cfg(2'd0, 32'd0, 32'h00FFFFFF, "rd_255");
        do_cfg(2'd2, 32'd0, 32'h00FFFFFF, "restore");
        do_cfg(2'd0, 32'd0, 32'h0013B736, "rd_restored");

        // restarts while busy and foreign IDs must be ignored
        bif.start  = 1'b1;
        bif.isId   = CID;
        bif.valueA = 32'hFFFFFFFF;
        bif.valueB = 32'hFFFFFFFF;
        tick();
        bif.valueA = '0;
        bif.valueB = '0;
        chk("busy.c1_done", {31'd0, bif.done}, 32'd0);
        tick();
        chk("busy.c2_done", {31'd0, bif.done}, 32'd1);
        chk("busy.c2_res", bif.result, 32'hFAFAFAFA);
        bif.isId = FOREIGN;
        tick();
        bif.start = 1'b0;
        chk("busy.c3_done", {31'd0, bif.done}, 32'd0);
        chk("busy.c3_res", bif.result, 32'd0);
        tick();
        chk("busy.c4_done", {31'd0, bif.done}, 32'd0);

        bif.start = 1'b1;
        bif.isId  = FOREIGN;
        tick();
        bif.start = 1'b0;
        chk("foreign.c1_done", {31'd0, bif.done}, 32'd0);
        chk("foreign.c1_res", bif.result, 32'd0);
        tick();
        chk("foreign.c2_done", {31'd0, bif.done}, 32'd0);

        // reset mid-flight: no done, weights back to defaults
        do_cfg(2'd1, 32'h00FFFFFF, 32'h0013B736, "wr_pre_rst");
        bif.start  = 1'b1;
        bif.isId   = CID;
        bif.valueA = 32'hFFFFFFFF;
        bif.valueB = 32'hFFFFFFFF;
        tick();
        bif.start = 1'b0;
        reset     = 1'b1;
        #1;
        chk("midrst.done", {31'd0, bif.done}, 32'd0);
        tick();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("midrst.post%0d", i), {31'd0, bif.done}, 32'd0);
            tick();
        end
        do_cfg(2'd0, 32'd0, 32'h0013B736, "rd_post_rst");

        do_cvt(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFAFAFAFA, "stats_cvt0");
        do_cvt(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFAFAFAFA, "stats_cvt1");
        do_cvt(32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFAFAFAFA, "stats_cvt2");
        do_cfg(2'd3, 32'd0, STATS_EXP, "stats_rd");
        do_cfg(2'd3, 32'd0, 32'd0, "stats_rd_again");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
